// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    LAUNCH
  } schedState_t;

  localparam logic [15:0] DAC_MIDSCALE = 16'h8000;
  localparam int          SAMPLE_BYTES = 4;
  localparam int          BYTE_IDX_W   = $clog2(SAMPLE_BYTES);

endpackage

// File: rtl/sample_rate_div.sv
// Sample-period divider: counts 0..SAMPLE_DIV-1 while enabled and flags the last count.
module sample_rate_div #(
  parameter int SAMPLE_DIV = 1134
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic enable,
  output logic sample_tick
);

  localparam int              DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] divCnt;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      divCnt <= '0;
    end else if (!enable || divCnt == LAST_CNT) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  assign sample_tick = (divCnt == LAST_CNT);

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces stereo samples from the write FIFO into the DAC serializer, one launch per sample period.
// Optional build macro DAC_SCHED_UNDERRUN_MUTE_EN: an empty-staging underrun launches midscale instead of holding.
module dac_sample_scheduler
  import dac_pkg::*;
#(
  parameter int SAMPLE_DIV = 1134,
  parameter int CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_valid,
  output logic             fifo_ready,
  input  logic             spi_busy,
  output logic             spi_start,
  output logic [15:0]      spi_word_a,
  output logic [15:0]      spi_word_b,
  output logic             sample_tick,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_count
);

  schedState_t            state, nextState;
  logic [BYTE_IDX_W-1:0]  byteIdx;
  logic                   stagedFull;
  logic [15:0]            stageA, stageB;
  logic [15:0]            wordA, wordB;
  logic                   startQ, underrunQ;
  logic [CNT_W-1:0]       underrunCnt;
  logic                   tick, fifoReady, xfer, lastByte;
  logic                   launchHit, underrunHit, muteHit;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sample_rate_div #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) uDiv (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .sample_tick (tick)
  );

  assign xfer     = fifoReady & fifo_valid;
  assign lastByte = (byteIdx == BYTE_IDX_W'(SAMPLE_BYTES - 1));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState   = state;
    fifoReady   = 1'b0;
    launchHit   = 1'b0;
    underrunHit = 1'b0;
    muteHit     = 1'b0;
    case (state)
      IDLE:   if (enable) nextState = FETCH;
      FETCH: begin
        fifoReady = 1'b1;
        if (fifo_valid && lastByte) nextState = HOLD;
      end
      HOLD: begin
        if (tick && stagedFull && !spi_busy) begin
          launchHit = 1'b1;
          nextState = LAUNCH;
        end
      end
      LAUNCH: nextState = FETCH;
      default: nextState = IDLE;
    endcase
    // Any tick that does not launch is a missed period, whatever the fetch progress.
    underrunHit = tick && !launchHit;
`ifdef DAC_SCHED_UNDERRUN_MUTE_EN
    muteHit = underrunHit && !stagedFull && !spi_busy;
`endif
    if (!enable) begin
      nextState   = IDLE;
      launchHit   = 1'b0;
      underrunHit = 1'b0;
      muteHit     = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      byteIdx     <= '0;
      stagedFull  <= 1'b0;
      startQ      <= 1'b0;
      underrunQ   <= 1'b0;
      underrunCnt <= '0;
      wordA       <= '0;
      wordB       <= '0;
    end else if (!enable) begin
      byteIdx    <= '0;
      stagedFull <= 1'b0;
      startQ     <= 1'b0;
      underrunQ  <= 1'b0;
    end else begin
      startQ <= launchHit | muteHit;
      if (xfer) begin
        byteIdx <= byteIdx + BYTE_IDX_W'(1);
        if (lastByte) stagedFull <= 1'b1;
      end
      if (state == LAUNCH) stagedFull <= 1'b0;
      if (launchHit) begin
        wordA <= stageA;
        wordB <= stageB;
      end else if (muteHit) begin
        wordA <= DAC_MIDSCALE;
        wordB <= DAC_MIDSCALE;
      end
      if (underrunHit) begin
        underrunQ   <= 1'b1;
        underrunCnt <= satInc(underrunCnt);
      end
    end
  end

  // Staging bytes arrive little-endian: A low, A high, B low, B high.
  always_ff @(posedge clk_in) begin
    if (xfer) begin
      case (byteIdx)
        2'd0:    stageA[7:0]  <= fifo_data;
        2'd1:    stageA[15:8] <= fifo_data;
        2'd2:    stageB[7:0]  <= fifo_data;
        default: stageB[15:8] <= fifo_data;
      endcase
    end
  end

  assign fifo_ready     = fifoReady;
  assign spi_start      = startQ;
  assign spi_word_a     = wordA;
  assign spi_word_b     = wordB;
  assign sample_tick    = tick;
  assign underrun       = underrunQ;
  assign underrun_count = underrunCnt;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler with a 64-cycle sample period and a byte-queue FIFO model.
module tb_dac_sample_scheduler;

  localparam int DIV = 64;
`ifdef DAC_SCHED_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset_n, enable, spi_busy;
  logic [7:0]  fifo_data;
  logic        fifo_valid, fifo_ready;
  logic        spi_start, sample_tick, underrun;
  logic [15:0] spi_word_a, spi_word_b, underrun_count;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] expA, expB;
  } vec_t;
  vec_t vecs[5];

  logic [7:0] fq[$];
  int  passed = 0, total = 0, cyc = 0;
  bit  monEn = 1'b0;
  int  lastTick = -1;
  bit  prevTick = 1'b0;

  dac_sample_scheduler #(.SAMPLE_DIV(DIV), .CNT_W(16)) dut (
    .clk_in         (clk_in),
    .reset_n        (reset_n),
    .enable         (enable),
    .fifo_data      (fifo_data),
    .fifo_valid     (fifo_valid),
    .fifo_ready     (fifo_ready),
    .spi_busy       (spi_busy),
    .spi_start      (spi_start),
    .spi_word_a     (spi_word_a),
    .spi_word_b     (spi_word_b),
    .sample_tick    (sample_tick),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #10 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic pushSample(input logic [15:0] a, input logic [15:0] b);
    fq.push_back(a[7:0]);
    fq.push_back(a[15:8]);
    fq.push_back(b[7:0]);
    fq.push_back(b[15:8]);
  endtask

  task automatic waitStart(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitTick(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (sample_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // FIFO consumer model: a handshake seen mid-cycle pops the head just after the edge.
  initial begin
    bit take;
    fifo_valid = 1'b0;
    fifo_data  = 8'h00;
    forever begin
      @(negedge clk_in);
      take = fifo_valid && fifo_ready;
      @(posedge clk_in);
      #1;
      if (take) void'(fq.pop_front());
      if (fq.size() > 0) begin
        fifo_valid = 1'b1;
        fifo_data  = fq[0];
      end else begin
        fifo_valid = 1'b0;
        fifo_data  = 8'h00;
      end
    end
  end

  // Tick spacing and start-follows-tick monitor.
  always @(negedge clk_in) begin
    if (!monEn || !enable) begin
      lastTick = -1;
      prevTick = 1'b0;
    end else begin
      if (spi_start) check("startAfterTick", prevTick, 1);
      if (sample_tick) begin
        if (lastTick >= 0) check("tickPeriod", cyc - lastTick, DIV);
        lastTick = cyc;
      end
      prevTick = sample_tick;
    end
  end

  initial begin
    bit ok;
    int e, t, starts;
    vecs[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 16'h1234, 16'h5678};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{8'h01, 8'h80, 8'hFE, 8'h7F, 16'h8001, 16'h7FFE};
    vecs[4] = '{8'hCD, 8'hAB, 8'h01, 8'hEF, 16'hABCD, 16'hEF01};

    reset_n  = 1'b0;
    enable   = 1'b0;
    spi_busy = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rstStart", spi_start, 0);
    check("rstWordA", spi_word_a, 0);
    check("rstWordB", spi_word_b, 0);
    check("rstTick", sample_tick, 0);
    check("rstUnderrun", underrun, 0);
    check("rstCount", underrun_count, 0);
    check("rstReady", fifo_ready, 0);
    reset_n = 1'b1;

    // Table: preload every vector, then expect one launch per period in order.
    foreach (vecs[i]) begin
      fq.push_back(vecs[i].b0);
      fq.push_back(vecs[i].b1);
      fq.push_back(vecs[i].b2);
      fq.push_back(vecs[i].b3);
    end
    repeat (2) @(negedge clk_in);
    monEn  = 1'b1;
    enable = 1'b1;
    e      = cyc;
    for (int i = 0; i < 5; i++) begin
      waitStart(200, ok);
      check("vecStart", ok, 1);
      if (i == 0) check("firstLatency", cyc - e, DIV);
      check("vecWordA", spi_word_a, vecs[i].expA);
      check("vecWordB", spi_word_b, vecs[i].expB);
      @(negedge clk_in);
      check("startPulse", spi_start, 0);
    end
    check("vecCount", underrun_count, 0);

    // 100 back-to-back samples with the FIFO never running dry.
    for (int n = 0; n < 100; n++) pushSample({n[7:0], 8'hA5}, {~n[7:0], 8'h5A});
    starts = 0;
    for (int n = 0; n < 100; n++) begin
      waitStart(100, ok);
      if (!ok) begin
        check("contStart", ok, 1);
        break;
      end
      starts++;
    end
    check("contStarts", starts, 100);
    check("contWordA", spi_word_a, 16'h63A5);
    check("contWordB", spi_word_b, 16'h9C5A);
    check("contCount", underrun_count, 0);
    check("contUnderrun", underrun, 0);

    // Two samples, then the FIFO runs dry for three ticks.
    enable = 1'b0;
    repeat (2) @(negedge clk_in);
    pushSample(16'hA1A0, 16'hB1B0);
    pushSample(16'hC3C2, 16'hD5D4);
    repeat (2) @(negedge clk_in);
    enable = 1'b1;
    starts = 0;
    repeat (322) begin
      @(negedge clk_in);
      if (spi_start) starts++;
    end
    check("dryStarts", starts, MUTE ? 5 : 2);
    check("dryUnderrun", underrun, 1);
    check("dryCount", underrun_count, 3);
    check("dryWordA", spi_word_a, MUTE ? 16'h8000 : 16'hC3C2);
    check("dryWordB", spi_word_b, MUTE ? 16'h8000 : 16'hD5D4);

    // Half a sample at a tick is an underrun; the two bytes are kept.
    fq.push_back(8'h01);
    fq.push_back(8'h02);
    waitTick(100, ok);
    check("partTick", ok, 1);
    @(negedge clk_in);
    check("partStart", spi_start, MUTE ? 1 : 0);
    check("partCount", underrun_count, 4);
    fq.push_back(8'h03);
    fq.push_back(8'h04);
    waitStart(100, ok);
    check("partLaunch", ok, 1);
    check("partWordA", spi_word_a, 16'h0201);
    check("partWordB", spi_word_b, 16'h0403);

    // Enable drop: flag clears, count and words hold; mid-fetch drop restarts the byte index.
    @(negedge clk_in);
    enable = 1'b0;
    @(negedge clk_in);
    check("offUnderrun", underrun, 0);
    check("offCount", underrun_count, 4);
    check("offWordA", spi_word_a, 16'h0201);
    check("offWordB", spi_word_b, 16'h0403);
    check("offReady", fifo_ready, 0);
    fq.push_back(8'hEE);
    fq.push_back(8'hEE);
    repeat (2) @(negedge clk_in);
    enable = 1'b1;
    repeat (6) @(negedge clk_in);
    check("stubTaken", fq.size(), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk_in);
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    fq.push_back(8'h33);
    fq.push_back(8'h44);
    repeat (2) @(negedge clk_in);
    enable = 1'b1;
    e      = cyc;
    waitStart(200, ok);
    check("reenStart", ok, 1);
    check("reenLatency", cyc - e, DIV);
    check("reenWordA", spi_word_a, 16'h2211);
    check("reenWordB", spi_word_b, 16'h4433);
    check("reenUnderrun", underrun, 0);
    check("reenCount", underrun_count, 4);

    // Serializer busy across a tick with a staged sample.
    pushSample(16'h6655, 16'h8877);
    spi_busy = 1'b1;
    waitTick(100, ok);
    check("busyTick", ok, 1);
    t = cyc;
    @(negedge clk_in);
    check("busyNoStart", spi_start, 0);
    check("busyCount", underrun_count, 5);
    check("busyUnderrun", underrun, 1);
    spi_busy = 1'b0;
    waitStart(100, ok);
    check("busyLaunch", ok, 1);
    check("busyDelay", cyc - t, DIV + 1);
    check("busyWordA", spi_word_a, 16'h6655);
    check("busyWordB", spi_word_b, 16'h8877);

    // Asynchronous reset in the LAUNCH cycle.
    pushSample(16'hBC9A, 16'hF0DE);
    waitStart(100, ok);
    check("rstLaunch", ok, 1);
    monEn = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("arstStart", spi_start, 0);
    check("arstWordA", spi_word_a, 0);
    check("arstWordB", spi_word_b, 0);
    check("arstUnderrun", underrun, 0);
    check("arstCount", underrun_count, 0);
    check("arstTick", sample_tick, 0);
    check("arstReady", fifo_ready, 0);
    @(negedge clk_in);
    reset_n = 1'b1;
    e       = cyc;
    waitTick(200, ok);
    check("arstTickSeen", ok, 1);
    check("arstDivRestart", cyc - e, DIV - 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
- Paces sample delivery to the DAC serializer inside the DAC control path, in the Nexys2 50 MHz clock domain.
- Pulls little-endian stereo sample bytes from the write FIFO consumer side and assembles 16-bit A/B words.
- Fires one serializer transfer per sample period and accounts for FIFO underruns.

Parameters:
- SAMPLE_DIV, 1134: clk_in cycles per sample period (50 MHz / 1134 ≈ 44.09 kHz); legal range ≥ 64.
- CNT_W, 16: width of underrun_count.

Ports:
- clk_in  in  1  50 MHz system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run; 0 = stop pacing and flush the staged sample.
- fifo_data  in  8  byte from the FIFO consumer port.
- fifo_valid  in  1  FIFO has a byte.
- fifo_ready  out  1  scheduler accepts the byte this cycle.
- spi_busy  in  1  serializer is shifting.
- spi_start  out  1  one-cycle launch pulse.
- spi_word_a  out  16  channel A word; held stable while spi_busy.
- spi_word_b  out  16  channel B word; held stable while spi_busy.
- sample_tick  out  1  one-cycle pulse at each period boundary.
- underrun  out  1  sticky flag; cleared when enable falls.
- underrun_count  out  CNT_W  saturating count of missed periods.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, divider 0, staging empty.
- Divider:
  - counts 0..SAMPLE_DIV-1 while enable=1; wraps to 0;
  - sample_tick=1 in the cycle the divider equals SAMPLE_DIV-1;
  - held at 0 while enable=0.
- Byte transfer occurs when fifo_valid & fifo_ready are both 1 in the same cycle.
- Byte order per sample: A[7:0], A[15:8], B[7:0], B[15:8].
- FSM states and transitions:
  - IDLE: fifo_ready=0. Go to FETCH when enable=1.
  - FETCH: fifo_ready=1; 2-bit byte index increments on each transfer. After the 4th byte, set staged_full=1 and go to HOLD.
  - HOLD: fifo_ready=0. On sample_tick:
    - if spi_busy=0: copy staging to spi_word_a/b, pulse spi_start in the next cycle, go to LAUNCH;
    - if spi_busy=1: treat as an underrun.
  - LAUNCH: spi_start=1 for exactly 1 cycle; clear staged_full; go to FETCH.
- Prefetch: the next sample is fetched during the current transfer. Only one staging register exists; spi_word_a/b are separate output registers.
- Launch latency: tick cycle + 1 → spi_start.
- Underrun: a tick with staged_full=0 (including a partial fetch), or with spi_busy=1.
  - spi_start stays 0 and spi_word_a/b are unchanged (last sample repeats in the analog domain).
  - underrun set; underrun_count += 1, saturating at all-ones.
  - A partially fetched sample is kept, and fetching continues.
- enable 1→0, in any state:
  - next cycle: FSM goes to IDLE, byte index and staged_full clear, underrun clears;
  - underrun_count holds its value;
  - spi_word_a/b hold; an in-flight serializer transfer is not aborted.
- A byte arriving in the same cycle as a tick is accepted normally. The tick evaluates staged_full as registered before that cycle.
- An asynchronous reset mid-transfer returns everything to reset values immediately.

Optional Feature:
- Macro: DAC_SCHED_UNDERRUN_MUTE_EN.
- Defined: on an underrun caused by staged_full=0 while spi_busy=0:
  - load spi_word_a/b = 16'h8000 (midscale);
  - pulse spi_start;
  - still count the underrun.
- Undefined: hold the last sample, with no launch (as above).

Decomposition:
- Shared package dac_pkg holds:
  - FSM state enum {IDLE, FETCH, HOLD, LAUNCH};
  - DAC_MIDSCALE = 16'h8000;
  - SAMPLE_BYTES = 4.
- One natural sub-module: sample_rate_div (divider plus sample_tick generation), parameterised by SAMPLE_DIV.

Test Plan:
- Reset and enable with FIFO preloaded with bytes 34 12 78 56:
  - first tick + 1 cycle → spi_start=1 for 1 cycle;
  - spi_word_a=16'h1234, spi_word_b=16'h5678.
- SAMPLE_DIV=64, continuous FIFO data:
  - sample_tick period exactly 64 cycles;
  - one spi_start per tick;
  - 100 samples with 0 underruns.
- FIFO empty after 2 samples:
  - 3 missed ticks → underrun=1, underrun_count=3;
  - words hold the 2nd sample;
  - with DAC_SCHED_UNDERRUN_MUTE_EN: 3 launches of 16'h8000/16'h8000.
- spi_busy forced high across a tick with a staged sample:
  - no spi_start, underrun_count +1;
  - launch occurs at the next tick after busy falls.
- Drop enable mid-FETCH after 2 bytes, then re-enable:
  - next sample uses the 4 fresh bytes (index restarted);
  - underrun cleared, count retained.
- Pulse reset_n low mid-LAUNCH, asynchronously:
  - all outputs 0 within the same cycle;
  - divider restarts at 0.
